// File: rtl/conv_mac_scheduler.sv
// Sequencer for a shared 3x3 multiplier array: loads kernel/data rows, accumulates over channels, emits pixels.
// Optional MAC_SCHED_SATURATE_EN clamps the output pixel to 16-bit signed range instead of wrapping.
module conv_mac_scheduler #(
  parameter int ACC_WIDTH = 32,
  parameter int MAX_CH    = 64,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_CH+1)-1:0]  num_ch,
  input  logic [CNT_W-1:0]             num_px,
  input  logic [47:0]                  k_row,
  input  logic                         k_valid,
  output logic                         k_ready,
  input  logic [47:0]                  d_row,
  input  logic                         d_valid,
  output logic                         d_ready,
  output logic [47:0]                  arr_kernel [0:2],
  output logic [47:0]                  arr_data [0:2],
  input  logic [47:0]                  arr_product [0:2],
  output logic [15:0]                  out_pix,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int CH_W = $clog2(MAX_CH+1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_K = 3'd1;
  localparam logic [2:0] S_LOAD_D = 3'd2;
  localparam logic [2:0] S_MAC    = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -ACC_WIDTH'(32768);

  logic [2:0]                  state;
  logic [1:0]                  row;
  logic [CH_W-1:0]             ch_cnt, ch_lim;
  logic [CNT_W-1:0]            px_cnt, px_lim;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] lane_sum;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic [15:0]                 pix_next;

  assign k_ready = (state == S_LOAD_K);
  assign d_ready = (state == S_LOAD_D);
  assign busy    = (state != S_IDLE);

  always_comb begin
    lane_sum = '0;
    for (int r = 0; r < 3; r++) begin
      for (int kx = 0; kx < 3; kx++) begin
        lane_sum = lane_sum + {{(ACC_WIDTH-16){arr_product[r][16*kx+15]}}, arr_product[r][16*kx +: 16]};
      end
    end
    acc_next = acc + lane_sum;
  end

`ifdef MAC_SCHED_SATURATE_EN
  always_comb begin
    if (acc_next > SAT_MAX)      pix_next = 16'h7FFF;
    else if (acc_next < SAT_MIN) pix_next = 16'h8000;
    else                         pix_next = acc_next[15:0];
  end
`else
  always_comb begin
    pix_next = acc_next[15:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      ch_cnt    <= '0;
      ch_lim    <= '0;
      px_cnt    <= '0;
      px_lim    <= '0;
      acc       <= '0;
      out_pix   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        arr_kernel[r] <= '0;
        arr_data[r]   <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Zero counts degrade to a single channel / single pixel.
            ch_lim <= (num_ch == '0) ? CH_W'(1) : num_ch;
            px_lim <= (num_px == '0) ? CNT_W'(1) : num_px;
            ch_cnt <= '0;
            px_cnt <= '0;
            acc    <= '0;
            row    <= '0;
            state  <= S_LOAD_K;
          end
        end
        S_LOAD_K: begin
          if (k_valid) begin
            arr_kernel[row] <= k_row;
            if (row == 2'd2) begin
              row   <= '0;
              state <= S_LOAD_D;
            end else begin
              row <= row + 2'd1;
            end
          end
        end
        S_LOAD_D: begin
          if (d_valid) begin
            arr_data[row] <= d_row;
            if (row == 2'd2) begin
              row   <= '0;
              state <= S_MAC;
            end else begin
              row <= row + 2'd1;
            end
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (ch_cnt == ch_lim - CH_W'(1)) begin
            ch_cnt    <= '0;
            out_pix   <= pix_next;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            ch_cnt <= ch_cnt + CH_W'(1);
            state  <= S_LOAD_K;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            if (px_cnt == px_lim - CNT_W'(1)) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              px_cnt <= px_cnt + CNT_W'(1);
              state  <= S_LOAD_K;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_scheduler.sv
// Scoreboard bench for conv_mac_scheduler: expected pixels queued per job, a monitor compares on each accept.
// Expected saturation result follows MAC_SCHED_SATURATE_EN.
module tb_conv_mac_scheduler;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [6:0]  num_ch;
  logic [15:0] num_px;
  logic [47:0] k_row, d_row;
  logic        k_valid, k_ready, d_valid, d_ready;
  logic [47:0] arr_kernel [0:2];
  logic [47:0] arr_data [0:2];
  logic [47:0] arr_product [0:2];
  logic [15:0] out_pix;
  logic        out_valid, out_ready, busy, done;

  int checks = 0, failures = 0;
  int cyc = 0, k_acc = 0, d_acc = 0, acc_count = 0, done_cnt = 0, last_acc_cyc = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  conv_mac_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .num_ch(num_ch), .num_px(num_px),
    .k_row(k_row), .k_valid(k_valid), .k_ready(k_ready),
    .d_row(d_row), .d_valid(d_valid), .d_ready(d_ready),
    .arr_kernel(arr_kernel), .arr_data(arr_data), .arr_product(arr_product),
    .out_pix(out_pix), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  // Multiplier array model: Q-format lane product, upper half of the 32-bit product.
  function automatic logic [15:0] lane_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[31:16];
  endfunction

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      arr_product[r] = '0;
      for (int kx = 0; kx < 3; kx++)
        arr_product[r][16*kx +: 16] = lane_mul(arr_kernel[r][16*kx +: 16], arr_data[r][16*kx +: 16]);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (k_valid && k_ready) k_acc <= k_acc + 1;
    if (d_valid && d_ready) d_acc <= d_acc + 1;
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pixel actual=%0h required=none", out_pix);
      end else begin
        check("out_pix", {32'h0, out_pix}, {32'h0, exp_q.pop_front()});
      end
      acc_count++;
      last_acc_cyc = cyc;
    end
    if (done) done_cnt++;
  end

  task automatic feed_k(input logic [15:0] v, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    k_row = {3{v}};
    k_valid = 1'b1;
    while (!k_ready && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) check("k_ready_timeout", 48'd0, 48'd1);
    @(negedge clk);
    k_valid = 1'b0;
  endtask

  task automatic feed_d(input logic [15:0] v, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    d_row = {3{v}};
    d_valid = 1'b1;
    while (!d_ready && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) check("d_ready_timeout", 48'd0, 48'd1);
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic run_job(input int nch, input int npx, input logic [15:0] kbase, input logic [15:0] kstep,
                         input logic [15:0] dval, input int maxgap,
                         input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    logic [15:0] e [3];
    int eff_ch, eff_px, t;
    e[0] = e0; e[1] = e1; e[2] = e2;
    eff_ch = (nch == 0) ? 1 : nch;
    eff_px = (npx == 0) ? 1 : npx;
    for (int p = 0; p < eff_px; p++) exp_q.push_back(e[p]);
    num_ch = 7'(nch);
    num_px = 16'(npx);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < eff_px; p++)
      for (int c = 0; c < eff_ch; c++) begin
        for (int r = 0; r < 3; r++) feed_k(kbase + 16'(p) * kstep, $urandom_range(0, maxgap));
        for (int r = 0; r < 3; r++) feed_d(dval, $urandom_range(0, maxgap));
      end
    t = 0;
    while (!done && t < 2000) begin @(negedge clk); t++; end
    check("done_seen", {47'h0, done}, 48'd1);
    check("done_latency", 48'(cyc - last_acc_cyc), 48'd1);
    check("queue_empty", 48'(exp_q.size()), 48'd0);
    @(negedge clk);
    check("done_pulse_end", {47'h0, done}, 48'd0);
    check("busy_after_job", {47'h0, busy}, 48'd0);
  endtask

  task automatic stall_second_pixel(input int base);
    int t = 0;
    logic [15:0] cap;
    while (acc_count < base + 1 && t < 2000) begin @(negedge clk); t++; end
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 2000) begin @(negedge clk); t++; end
    check("stall_valid_seen", {47'h0, out_valid}, 48'd1);
    cap = out_pix;
    check("stall_pix_value", {32'h0, cap}, 48'd18);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid_held", {47'h0, out_valid}, 48'd1);
      check("stall_pix_held", {32'h0, out_pix}, {32'h0, cap});
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kb, db, dn;
    rst = 1'b1; start = 1'b0; num_ch = '0; num_px = '0;
    k_row = '0; d_row = '0; k_valid = 1'b0; d_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {47'h0, busy}, 48'd0);
    check("rst_k_ready", {47'h0, k_ready}, 48'd0);
    check("rst_d_ready", {47'h0, d_ready}, 48'd0);
    check("rst_out_valid", {47'h0, out_valid}, 48'd0);
    check("rst_done", {47'h0, done}, 48'd0);
    check("rst_out_pix", {32'h0, out_pix}, 48'd0);
    check("rst_arr_kernel", arr_kernel[1], 48'd0);
    check("rst_arr_data", arr_data[2], 48'd0);

    run_job(1, 1, 16'h0100, 16'h0000, 16'h0100, 0, 16'd9, 16'd0, 16'd0);

    kb = k_acc; db = d_acc;
    run_job(2, 1, 16'h0100, 16'h0000, 16'h0100, 1, 16'd18, 16'd0, 16'd0);
    check("k_beats_2ch", 48'(k_acc - kb), 48'd6);
    check("d_beats_2ch", 48'(d_acc - db), 48'd6);

`ifdef MAC_SCHED_SATURATE_EN
    run_job(1, 1, 16'h4000, 16'h0000, 16'h4000, 0, 16'h7FFF, 16'd0, 16'd0);
`else
    run_job(1, 1, 16'h4000, 16'h0000, 16'h4000, 0, 16'h9000, 16'd0, 16'd0);
`endif

    run_job(3, 1, 16'hFF00, 16'h0000, 16'h0100, 0, 16'hFFE5, 16'd0, 16'd0);
    run_job(0, 0, 16'h0200, 16'h0000, 16'h0100, 0, 16'd18, 16'd0, 16'd0);

    fork
      run_job(1, 3, 16'h0100, 16'h0100, 16'h0100, 0, 16'd9, 16'd18, 16'd27);
      stall_second_pixel(acc_count);
    join

    // Abort in the middle of loading data rows.
    dn = done_cnt;
    num_ch = 7'd1; num_px = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 3; r++) feed_k(16'h0300, $urandom_range(0, 3));
    feed_d(16'h0100, $urandom_range(0, 3));
    check("pre_abort_d_ready", {47'h0, d_ready}, 48'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {47'h0, busy}, 48'd0);
    check("abort_k_ready", {47'h0, k_ready}, 48'd0);
    check("abort_d_ready", {47'h0, d_ready}, 48'd0);
    check("abort_out_valid", {47'h0, out_valid}, 48'd0);
    check("abort_arr_kernel", arr_kernel[0], 48'd0);
    check("abort_arr_data", arr_data[0], 48'd0);
    repeat (4) @(negedge clk);
    check("abort_no_done", 48'(done_cnt - dn), 48'd0);

    run_job(2, 2, 16'h0100, 16'h0100, 16'h0200, 3, 16'd36, 16'd72, 16'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
